axis_spi_master_mc: RTL
=======================

// Module: axis_spi_master_mc
// PURPOSE
//  Parametrised AXI-Stream SPI master: DATA_WIDTH-bit words, CS_NUM chip selects, all four CPOL/CPHA modes, MSB/LSB-first.
//  s_axis words are shifted out on MOSI; MISO words are returned on m_axis.
//  Sits behind the axis_spi register block, which drives the config inputs.
//  tlast=0 keeps CS asserted across words for multi-word bursts.
// PARAMETERS
//  DATA_WIDTH     8   word length in bits, legal range 4..32
//  CS_NUM         4   number of chip selects, >=1
//  DIVIDER_WIDTH  32  width of clk_divider_i
// PORTS
//  clk_i            in   1              system clock
//  arstn_i          in   1              asynchronous reset, active-low
//  clk_divider_i    in   DIVIDER_WIDTH  SCLK half-period in clk_i cycles; 0 behaves as 1
//  cpol_i           in   1              SCLK idle level
//  cpha_i           in   1              0: sample on leading edge; 1: sample on trailing edge
//  lsb_first_i      in   1              1: LSB shifted first
//  cs_sel_i         in   $clog2(CS_NUM) index of the active chip select (width 1 when CS_NUM=1)
//  s_axis_tdata_i   in   DATA_WIDTH     TX word
//  s_axis_tvalid_i  in   1              TX valid
//  s_axis_tlast_i   in   1              1: release CS after this word
//  s_axis_tready_o  out  1              TX ready
//  m_axis_tdata_o   out  DATA_WIDTH     RX word
//  m_axis_tvalid_o  out  1              RX valid
//  m_axis_tready_i  in   1              RX ready
//  spi_sclk_o       out  1              SPI clock
//  spi_mosi_o       out  1              SPI data out
//  spi_miso_i       in   1              SPI data in
//  spi_cs_n_o       out  CS_NUM         chip selects, active-low
//  busy_o           out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset values: sclk=cpol_i; mosi=0; cs_n=all 1; s_tready=0; m_tvalid=0; m_tdata=0; busy=0; FSM=IDLE.
//  Config latch: cpol/cpha/lsb_first/cs_sel/divider are latched on the first s_axis handshake of a burst.
//   Changes to these inputs mid-burst are ignored until the FSM returns to IDLE.
//  s_axis_tready_o=1 only in IDLE, and in WAIT_NEXT when no RX word is pending.
//  FSM states and transitions:
//   IDLE: on handshake, latch word -> LEAD. cs_n[sel]=0 in the same cycle as the handshake.
//   LEAD: one half-period of CS setup -> SHIFT.
//   SHIFT: 2*DATA_WIDTH SCLK edges, one edge per half-period.
//    CPHA=0: first bit driven in LEAD; sample on odd edges; shift on even edges.
//    CPHA=1: shift on odd edges; sample on even edges.
//    Then -> TRAIL.
//   TRAIL: one half-period, SCLK held at CPOL.
//    Push the RX word: m_tvalid=1, m_tdata=rx shift register, bit order reversed to match lsb_first.
//    If the RX slot is still full (previous word unaccepted), stall in TRAIL with SCLK frozen; no data is lost.
//    Then: tlast=1 -> GAP; tlast=0 -> WAIT_NEXT.
//   WAIT_NEXT: CS stays low, SCLK=CPOL. On handshake -> SHIFT directly (no LEAD).
//   GAP: cs_n all 1 for one half-period (minimum CS-high time) -> IDLE.
//  m_axis: single-entry output register. tvalid stays high until tready; tdata is stable while tvalid && !tready.
//  Divider: counter reloads to max(divider,1)-1 and ticks one edge at 0.
//   Divider=1 gives SCLK = clk_i/2.
//  Only cs_n[cs_sel] ever toggles. cs_sel >= CS_NUM is treated as 0.
//  arstn_i low mid-word: aborts immediately; all outputs return to reset values; the partial RX word is discarded.
// CONFIGURATION
//  SPI_LOOPBACK_EN defined:
//   Adds input port loopback_i (1 bit). When high, the MISO sampler reads the internal MOSI.
//   spi_miso_i is ignored; the pins still toggle.
//  SPI_LOOPBACK_EN undefined: no loopback_i port; the sampler always reads spi_miso_i.
// STRUCTURE
//  axis_spi_pkg gains:
//   spi_state_e enum {IDLE, LEAD, SHIFT, TRAIL, WAIT_NEXT, GAP}
//   spi_cfg_t packed struct {cpol, cpha, lsb_first, cs_sel}
//   MAX_DATA_WIDTH = 32
//  Sub-module spi_edge_gen:
//   Divider counter plus edge counter.
//   Emits lead_edge/trail_edge strobes and last_edge; start/stop controlled by the FSM.
// TESTING
//  Mode 0, divider=2, tx 0xA5, MISO slave model returns 0x3C, tlast=1
//   -> MOSI 1,0,1,0,0,1,0,1 at rising edges; m_tdata=0x3C; 8 SCLK periods of 4 clk each; CS high afterwards.
//  Mode 3, lsb_first=1, tx 0x81 -> MOSI first bit 1, SCLK idles high, RX word bit-reversed correctly.
//  Burst of 3 words (0x11, 0x22, 0x33; tlast only on the last) on cs_sel=2
//   -> cs_n=4'b1011 continuously for all 3 words; 3 RX beats.
//  m_axis_tready=0 for 100 cycles during a 2-word burst -> FSM stalls in TRAIL; both RX words are delivered in order.
//  Divider=0 -> identical timing to divider=1 (SCLK=clk/2).
//  arstn_i low at edge 5 -> all outputs return to reset values immediately; a new word after reset transfers cleanly.

Source files
------------

// File: rtl/axis_spi_pkg.sv
// Shared types for the AXI-Stream SPI master: FSM state encoding, latched
// per-burst configuration and the widest supported word.
package axis_spi_pkg;

   localparam int MAX_DATA_WIDTH = 32;
   localparam int MAX_CS_SEL_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL,
      WAIT_NEXT,
      GAP
   } spi_state_e;

   typedef struct packed {
      logic                    cpol;
      logic                    cpha;
      logic                    lsb_first;
      logic [MAX_CS_SEL_W-1:0] cs_sel;
   } spi_cfg_t;

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK timing for the SPI master: a half-period down-counter that ticks at
// zero and reloads, plus a count of SCLK edges within one word.
module spi_edge_gen #(
   parameter int DATA_WIDTH    = 8,
   parameter int DIVIDER_WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic                     start_i,
   input  logic                     run_i,
   input  logic                     shift_i,
   input  logic [DIVIDER_WIDTH-1:0] reload_i,
   output logic                     tick_o,
   output logic                     lead_edge_o,
   output logic                     trail_edge_o,
   output logic                     last_edge_o
);

   localparam int EW = $clog2(2 * DATA_WIDTH);

   logic [DIVIDER_WIDTH-1:0] div_cnt_q;
   logic [EW-1:0]            edge_cnt_q;

   assign tick_o       = run_i && (div_cnt_q == '0);
   assign lead_edge_o  = tick_o && shift_i && !edge_cnt_q[0];
   assign trail_edge_o = tick_o && shift_i && edge_cnt_q[0];
   assign last_edge_o  = trail_edge_o && (edge_cnt_q == EW'(2 * DATA_WIDTH - 1));

   // Half-period countdown; edges are only counted while the FSM is shifting.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
      end else if (start_i) begin
         div_cnt_q  <= reload_i;
         edge_cnt_q <= '0;
      end else if (run_i) begin
         if (div_cnt_q == '0) begin
            div_cnt_q <= reload_i;
            if (shift_i) edge_cnt_q <= edge_cnt_q + 1'b1;
         end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_spi_master_mc.sv
// AXI-Stream SPI master, all CPOL/CPHA modes, MSB/LSB-first, multi-word bursts
// held under one chip select while tlast=0.
// Optional build macro SPI_LOOPBACK_EN adds loopback_i (MISO sampler reads MOSI).
//
// state     | meaning
// IDLE      | CS high, waiting for the first word of a burst
// LEAD      | CS low, one half-period of setup before the first SCLK edge
// SHIFT     | 2*DATA_WIDTH SCLK edges, one per half-period
// TRAIL     | one half-period with SCLK at CPOL, then push RX word (stall if slot full)
// WAIT_NEXT | mid-burst, CS held low, waiting for the next word
// GAP       | CS high for one half-period before returning to IDLE
module axis_spi_master_mc
   import axis_spi_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int CS_NUM        = 4,
   parameter int DIVIDER_WIDTH = 32,
   localparam int CS_W         = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
`ifdef SPI_LOOPBACK_EN
   input  logic                     loopback_i,
`endif
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic                     cpol_i,
   input  logic                     cpha_i,
   input  logic                     lsb_first_i,
   input  logic [CS_W-1:0]          cs_sel_i,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata_i,
   input  logic                     s_axis_tvalid_i,
   input  logic                     s_axis_tlast_i,
   output logic                     s_axis_tready_o,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
   output logic                     m_axis_tvalid_o,
   input  logic                     m_axis_tready_i,
   output logic                     spi_sclk_o,
   output logic                     spi_mosi_o,
   input  logic                     spi_miso_i,
   output logic [CS_NUM-1:0]        spi_cs_n_o,
   output logic                     busy_o
);

   spi_state_e               state_q;
   spi_cfg_t                 cfg_q;
   logic [DIVIDER_WIDTH-1:0] div_q;
   logic [DATA_WIDTH-1:0]    tx_q, rx_q, m_data_q;
   logic                     m_valid_q, sclk_q, mosi_q, last_q, ready_en_q;
   logic [CS_NUM-1:0]        cs_n_q;

   logic [CS_W-1:0]          sel_eff;
   logic [DATA_WIDTH-1:0]    tx_rev, rx_rev, load_word, rx_word;
   logic [DIVIDER_WIDTH-1:0] div_src, reload;
   logic                     s_hs, cpha_eff, lsb_eff, miso_src, slot_free;
   logic                     run, tick, lead_edge, trail_edge, last_edge;
   logic                     do_sample, do_shift;

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev
      assign tx_rev[i] = s_axis_tdata_i[DATA_WIDTH-1-i];
      assign rx_rev[i] = rx_q[DATA_WIDTH-1-i];
   end

   // Config comes straight from the inputs on the first word, from the latch mid-burst.
   assign sel_eff   = (int'(cs_sel_i) < CS_NUM) ? cs_sel_i : '0;
   assign cpha_eff  = (state_q == IDLE) ? cpha_i : cfg_q.cpha;
   assign lsb_eff   = (state_q == IDLE) ? lsb_first_i : cfg_q.lsb_first;
   assign div_src   = (state_q == IDLE) ? clk_divider_i : div_q;
   assign reload    = (div_src == '0) ? '0 : div_src - 1'b1;
   // Words are always shifted MSB-first internally; LSB-first is handled by reversal.
   assign load_word = lsb_eff ? tx_rev : s_axis_tdata_i;
   assign rx_word   = cfg_q.lsb_first ? rx_rev : rx_q;
   assign slot_free = !m_valid_q || m_axis_tready_i;
   assign s_hs      = s_axis_tvalid_i && s_axis_tready_o;
   assign run       = (state_q == LEAD) || (state_q == SHIFT) ||
                      (state_q == TRAIL) || (state_q == GAP);
   assign do_sample = cfg_q.cpha ? trail_edge : lead_edge;
   assign do_shift  = cfg_q.cpha ? lead_edge : (trail_edge && !last_edge);

`ifdef SPI_LOOPBACK_EN
   assign miso_src = loopback_i ? mosi_q : spi_miso_i;
`else
   assign miso_src = spi_miso_i;
`endif

   spi_edge_gen #(
      .DATA_WIDTH    (DATA_WIDTH),
      .DIVIDER_WIDTH (DIVIDER_WIDTH)
   ) u_edge_gen (
      .clk_i        (clk_i),
      .arstn_i      (arstn_i),
      .start_i      (s_hs),
      .run_i        (run),
      .shift_i      (state_q == SHIFT),
      .reload_i     (reload),
      .tick_o       (tick),
      .lead_edge_o  (lead_edge),
      .trail_edge_o (trail_edge),
      .last_edge_o  (last_edge)
   );

   // Sequencer: CS/SCLK/MOSI generation, RX assembly and the single-entry RX slot.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= IDLE;
         cfg_q      <= '0;
         div_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         last_q     <= 1'b0;
         ready_en_q <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         ready_en_q <= 1'b1;
         if (m_valid_q && m_axis_tready_i) m_valid_q <= 1'b0;
         if (s_hs) begin
            last_q <= s_axis_tlast_i;
            rx_q   <= '0;
            if (!cpha_eff) begin
               mosi_q <= load_word[DATA_WIDTH-1];
               tx_q   <= load_word << 1;
            end else begin
               tx_q   <= load_word;
            end
         end
         case (state_q)
            IDLE: if (s_hs) begin
               cfg_q   <= '{cpol: cpol_i, cpha: cpha_i, lsb_first: lsb_first_i,
                            cs_sel: MAX_CS_SEL_W'(sel_eff)};
               div_q   <= clk_divider_i;
               sclk_q  <= cpol_i;
               cs_n_q  <= ~(CS_NUM'(1) << sel_eff);
               state_q <= LEAD;
            end
            LEAD: if (tick) state_q <= SHIFT;
            SHIFT: begin
               if (lead_edge || trail_edge) sclk_q <= ~sclk_q;
               if (do_sample) rx_q <= {rx_q[DATA_WIDTH-2:0], miso_src};
               if (do_shift) begin
                  mosi_q <= tx_q[DATA_WIDTH-1];
                  tx_q   <= tx_q << 1;
               end
               if (last_edge) state_q <= TRAIL;
            end
            TRAIL: begin
               sclk_q <= cfg_q.cpol;
               if (tick && slot_free) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= rx_word;
                  if (last_q) begin
                     cs_n_q  <= '1;
                     state_q <= GAP;
                  end else begin
                     state_q <= WAIT_NEXT;
                  end
               end
            end
            WAIT_NEXT: if (s_hs) begin
               cs_n_q  <= ~(CS_NUM'(1) << cfg_q.cs_sel);
               state_q <= SHIFT;
            end
            GAP: if (tick) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_axis_tready_o = ready_en_q &&
                            ((state_q == IDLE) || ((state_q == WAIT_NEXT) && !m_valid_q));
   assign m_axis_tdata_o  = m_data_q;
   assign m_axis_tvalid_o = m_valid_q;
   assign spi_sclk_o      = (state_q == IDLE) ? cpol_i : sclk_q;
   assign spi_mosi_o      = mosi_q;
   assign spi_cs_n_o      = cs_n_q;
   assign busy_o          = (state_q != IDLE);

endmodule
